// File: rtl/serial_subtractor_16bit_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface serial_subtractor_16bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, overflow
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, overflow
  );
endinterface

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, DIGIT bits per cycle from the LSB,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor_16bit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic                     clk,
  input logic                     rst,
  serial_subtractor_16bit_if.slave bus
);
  localparam int unsigned K    = WIDTH / DIGIT;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bout_q;
  logic             ovf_q;

  logic [DIGIT:0]   dig;
  logic             last;

  // Operands shift down each RUN cycle, so the active digit is always the low slice.
  always_comb begin
    dig = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
  end

  assign last = (cnt_q == CntW'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.bin;
            cnt_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          diff_q   <= {dig[DIGIT-1:0], diff_q[WIDTH-1:DIGIT]};
          borrow_q <= dig[DIGIT];
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            bout_q  <= dig[DIGIT];
            // On the last digit the low slice of a_q/b_q holds the original MSBs.
            ovf_q   <= (a_q[DIGIT-1] != b_q[DIGIT-1]) && (dig[DIGIT-1] != a_q[DIGIT-1]);
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit: directed corner cases, backpressure,
// mid-operation reset and a randomized back-to-back stream against an arithmetic model.
module tb_serial_subtractor_16bit;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  serial_subtractor_16bit_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_16bit #(.WIDTH(WIDTH), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, bout, diff} from plain unsigned and signed arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] full;
    int          sx;
    int          sy;
    int          sr;
    logic        ov;
    full = {1'b0, x} - {1'b0, y} - {16'd0, c};
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    sr   = sx - sy - int'(c);
    ov   = (sr > 32767) || (sr < -32768);
    return {ov, full[16], full[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands, completes the input handshake, then waits for out_valid.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                          output int lat);
    int n;
    bus.a = x;
    bus.b = y;
    bus.bin = c;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("release_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  logic [15:0] va [5] = '{16'h0005, 16'h0000, 16'h8000, 16'h7FFF, 16'h1234};
  logic [15:0] vb [5] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h0234};
  logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [17:0] vexp [5] = '{{2'b00, 16'h0002}, {2'b01, 16'hFFFF}, {2'b10, 16'h7FFF},
                            {2'b11, 16'h8000}, {2'b00, 16'h0FFF}};

  initial begin
    int          lat;
    logic [17:0] snap;
    logic [17:0] expq[$];
    int          cyc;
    int          idx;
    int          nres;
    int          last_cyc;
    logic        acc;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;

    // Reset state
    #1;
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_result", {14'd0, bus.overflow, bus.bout, bus.diff}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed corner cases
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vc[i], lat);
      check_eq($sformatf("dir%0d_result", i), {14'd0, bus.overflow, bus.bout, bus.diff},
               {14'd0, vexp[i]});
      if (i == 0) check_eq("latency", lat, 4);
      finish_op();
    end

    // Backpressure: result must hold and a new request must not be taken
    start_op(16'h1234, 16'h0001, 1'b0, lat);
    snap = {bus.overflow, bus.bout, bus.diff};
    check_eq("bp_result", {14'd0, snap}, {14'd0, model(16'h1234, 16'h0001, 1'b0)});
    bus.a = 16'hAAAA;
    bus.b = 16'h0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_hold", {14'd0, bus.overflow, bus.bout, bus.diff}, {14'd0, snap});
      check_eq("bp_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.in_valid = 1'b0;
    finish_op();

    // Reset in the middle of RUN discards the operation
    start_op(16'h00FF, 16'h0001, 1'b0, lat);
    finish_op();
    bus.a = 16'h00FF;
    bus.b = 16'h0001;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
    check_eq("midrst_diff", {16'd0, bus.diff}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("no_stale", {31'd0, bus.out_valid}, 32'd0);
    end
    start_op(16'h00FF, 16'h0001, 1'b0, lat);
    check_eq("after_rst_result", {14'd0, bus.overflow, bus.bout, bus.diff}, 32'h000FE);
    finish_op();

    // Back-to-back random stream with both handshakes held high
    idx = 0;
    nres = 0;
    cyc = 0;
    last_cyc = -1;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.bin = 1'($urandom);
    expq.push_back(model(bus.a, bus.b, bus.bin));
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    while (nres < 8 && cyc < 200) begin
      acc = bus.in_ready && bus.in_valid;
      if (bus.out_valid) begin
        check_eq($sformatf("b2b%0d_result", nres), {14'd0, bus.overflow, bus.bout, bus.diff},
                 {14'd0, expq.pop_front()});
        if (last_cyc >= 0) check_eq("b2b_spacing", cyc - last_cyc, 6);
        last_cyc = cyc;
        nres++;
      end
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) begin
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          bus.bin = 1'($urandom);
          expq.push_back(model(bus.a, bus.b, bus.bin));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check_eq("b2b_count", nres, 8);
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_16bit.md
# serial_subtractor_16bit

Multi-cycle digit-serial two's-complement subtractor that computes `diff = a - b - bin` for 16-bit operands. It is the subtract-direction companion to the 16-bit ripple adder in the arithmetic datapath. It processes `DIGIT` bits per clock from the LSB upward, and it accepts and returns operands through valid/ready handshakes.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per RUN cycle. `K = WIDTH/DIGIT` RUN cycles per operation.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands on `a`/`b`/`bin` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  `diff`/`bout`/`overflow` hold a completed result.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `a - b - bin`, modulo 2^WIDTH.
- `bout`  out  1  borrow out of the MSB; 1 iff unsigned `a < b + bin`.
- `overflow`  out  1  signed overflow of the subtraction.

## Operation
- Three states: IDLE, RUN, DONE. The state register and the digit counter are reset asynchronously to IDLE and 0.
- IDLE:
  - `in_ready = 1`.
  - When `in_valid && in_ready` on an edge, latch `a`, `b` and `bin`, clear the digit counter, and go to RUN.
  - When `in_valid` is low, stay in IDLE.
- RUN:
  - On each edge, digit `d` (bits `d*DIGIT +: DIGIT`) is computed as `a_d - b_d - borrow`.
  - The result digit is written into the `diff` register and `borrow` is updated. `borrow` starts at `bin`.
  - After digit `K-1`:
    - `bout` = final borrow.
    - `overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using latched `a`/`b` and the final `diff`.
    - Go to DONE.
- DONE:
  - `out_valid = 1`.
  - `diff`, `bout` and `overflow` stay stable until the edge where `out_ready` is high; that edge returns the block to IDLE.
  - Without `out_ready` the block stays in DONE indefinitely (backpressure).
- Input changes on `a`, `b`, `bin` and `in_valid` outside an IDLE handshake are ignored; only latched copies are used.
- After the result handshake, `diff`/`bout`/`overflow` keep their last values until the next operation overwrites them. They are only meaningful while `out_valid` is high.
- `in_ready` and `out_valid` are decoded from the state register, with no combinational path from inputs.
- While `rst` is high, `in_ready` is forced to 0.

## Timing
- Reset values: `in_ready = 0` while `rst` is high, and 1 in the first cycle after release. `out_valid = 0`, `diff = 0`, `bout = 0`, `overflow = 0`.
- Latency:
  - Input handshake at edge E0.
  - Digits are processed on edges E1..EK.
  - `out_valid` is high after edge EK: 4 cycles for the defaults.
- Throughput: with `out_ready` held high, one operation every K+2 cycles. The sequence is accept, K × RUN, DONE, then IDLE.
- Reset asserted in any state (including mid-RUN or in DONE with no `out_ready`):
  - Outputs go to their reset values immediately.
  - The partial result is discarded and nothing is emitted for that operation.
- `in_valid` high while in RUN or DONE: not accepted. The producer must hold `in_valid` until `in_ready`.

## Test plan
- `a=0x0005`, `b=0x0003`, `bin=0` → `diff=0x0002`, `bout=0`, `overflow=0`, with `out_valid` rising exactly 4 cycles after the accept edge.
- `a=0x0000`, `b=0x0001`, `bin=0` → `diff=0xFFFF`, `bout=1`, `overflow=0`. `a=0x8000`, `b=0x0001` → `diff=0x7FFF`, `bout=0`, `overflow=1`.
- `a=0x7FFF`, `b=0xFFFF`, `bin=0` → `diff=0x8000`, `bout=1`, `overflow=1`. `a=0x1234`, `b=0x0234`, `bin=1` → `diff=0x0FFF`, `bout=0`, `overflow=0`.
- Backpressure:
  - Hold `out_ready=0` for 10 cycles after `out_valid`.
  - `diff`, `bout` and `overflow` must not change, and `in_ready` must stay 0.
  - A concurrent `in_valid` with `a=0xAAAA` is not accepted.
  - Release `out_ready` → IDLE on the next edge.
- Assert `rst` after 2 RUN edges of `0x00FF - 0x0001`:
  - `out_valid=0`, `diff=0` and `in_ready=0` while reset is high.
  - After release, `0x00FF - 0x0001` → `diff=0x00FE` with no stale result emitted.
- Back-to-back: 8 random operand triples with `in_valid` and `out_ready` held high → each result matches a scoreboard, with spacing of 6 cycles per result.
